// File: rtl/tilelink_initiator_if.sv
// TL-UL channel types and the command/response/bus bundle of the initiator.
package TL;
    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    // a_ready travels with the A struct: the host's readiness for D beats.
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [2:0]  a_size;
        logic        a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        a_ready;
    } tilelink_a;

    // d_ready travels with the D struct: the device's acceptance of A requests.
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [2:0]  d_size;
        logic        d_source;
        logic [31:0] d_data;
        logic        d_error;
        logic        d_ready;
    } tilelink_d;
endpackage

interface tilelink_initiator_if;
    import TL::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_mask;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    tilelink_a   tla;
    tilelink_d   tld;

    modport master (
        input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_mask, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        input  rsp_ready,
        output tla,
        input  tld
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_mask, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        output rsp_ready,
        input  tla,
        output tld
    );
endinterface

// File: rtl/tilelink_initiator.sv
// TL-UL host initiator: one outstanding command, alignment check, source
// tagging and a response timeout.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SEND_A | A request on the bus until the device accepts it
// WAIT_D | waiting for the D response, timeout counting
// RESP   | response presented until the requester takes it
module tilelink_initiator
    import TL::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TW      = 8
) (
    input logic                  clock,
    input logic                  rst_n,
    tilelink_initiator_if.master bus
);

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SEND_A, WAIT_D, RESP} state_e;

    state_e      state_q, state_d;
    logic [2:0]  opcode_q, opcode_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] data_q, data_d;
    logic        tag_q, tag_d;
    logic        bus_txn_q, bus_txn_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
    logic        a_ready_q;

    logic [3:0]  nat_mask;
    logic        cmd_legal;
    logic [2:0]  cmd_opcode;
    logic        is_get;
    logic        d_done;
    logic        d_err;
    logic [TW-1:0] cnt_inc;
    tilelink_a   tla_o;
    logic        unused_tld;

    assign unused_tld = ^{bus.tld.d_param, bus.tld.d_size};

    // Natural byte lanes and alignment of the incoming command.
    always_comb begin
        nat_mask  = 4'b1111;
        cmd_legal = 1'b0;
        case (bus.cmd_size)
            3'd0: begin
                nat_mask  = 4'b0001 << bus.cmd_addr[1:0];
                cmd_legal = 1'b1;
            end
            3'd1: begin
                nat_mask  = 4'b0011 << bus.cmd_addr[1:0];
                cmd_legal = ~bus.cmd_addr[0];
            end
            3'd2: begin
                nat_mask  = 4'b1111;
                cmd_legal = (bus.cmd_addr[1:0] == 2'b00);
            end
            default: begin
                nat_mask  = 4'b1111;
                cmd_legal = 1'b0;
            end
        endcase

        if (!bus.cmd_write)
            cmd_opcode = Get;
        else if (bus.cmd_mask == nat_mask)
            cmd_opcode = PutFullData;
        else
            cmd_opcode = PutPartialData;
    end

    // Completion and error classification of the D channel while waiting.
    // A put may complete on a matching AccessAck even without d_valid.
    always_comb begin
        is_get  = (opcode_q == Get);
        d_done  = bus.tld.d_valid ||
                  (!is_get && (bus.tld.d_opcode == AccessAck) && (bus.tld.d_source == tag_q));
        d_err   = bus.tld.d_error ||
                  (bus.tld.d_opcode != (is_get ? AccessAckData : AccessAck)) ||
                  (bus.tld.d_source != tag_q);
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state, handshake outputs and response/command capture.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        size_d        = size_q;
        addr_d        = addr_q;
        mask_d        = mask_q;
        data_d        = data_q;
        tag_d         = tag_q;
        bus_txn_d     = bus_txn_q;
        cnt_d         = cnt_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    opcode_d    = cmd_opcode;
                    size_d      = bus.cmd_size;
                    addr_d      = bus.cmd_addr;
                    mask_d      = bus.cmd_write ? (bus.cmd_mask & nat_mask) : nat_mask;
                    data_d      = bus.cmd_write ? bus.cmd_wdata : 32'h0;
                    rsp_rdata_d = 32'h0;
                    cnt_d       = '0;
                    if (cmd_legal) begin
                        bus_txn_d   = 1'b1;
                        rsp_error_d = 1'b0;
                        state_d     = SEND_A;
                    end else begin
                        bus_txn_d   = 1'b0;
                        rsp_error_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            SEND_A: begin
                if (bus.tld.d_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_D;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_error_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_D: begin
                cnt_d = cnt_inc;
                if (d_done) begin
                    rsp_error_d = d_err;
                    rsp_rdata_d = (is_get && !d_err) ? bus.tld.d_data : 32'h0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    if (bus_txn_q)
                        tag_d = ~tag_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A-channel drive: fields come from the latched command.
    always_comb begin
        tla_o           = '0;
        tla_o.a_valid   = (state_q == SEND_A);
        tla_o.a_opcode  = opcode_q;
        tla_o.a_param   = 3'd0;
        tla_o.a_size    = size_q;
        tla_o.a_source  = tag_q;
        tla_o.a_address = addr_q;
        tla_o.a_mask    = mask_q;
        tla_o.a_data    = data_q;
        tla_o.a_ready   = a_ready_q;
    end

    assign bus.tla       = tla_o;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Command, tag, timeout and response registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q    <= 3'd0;
            size_q      <= 3'd0;
            addr_q      <= 32'h0;
            mask_q      <= 4'h0;
            data_q      <= 32'h0;
            tag_q       <= 1'b0;
            bus_txn_q   <= 1'b0;
            cnt_q       <= '0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
            a_ready_q   <= 1'b0;
        end else begin
            opcode_q    <= opcode_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
            bus_txn_q   <= bus_txn_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            a_ready_q   <= 1'b1;
        end
    end

endmodule
